// File: rtl/pz_reg_loader.sv
// pz_reg_loader
//   Loads pole/zero values from a 16-bit valid/ready word stream into a
//   REG_FILE_SIZE-slot register file and presents the flat_pz/no_z/no_p set
//   consumed by pz_accumulator. Each frame is collected in a shadow bank and
//   copied to the active set in a single COMMIT cycle. The downstream
//   accumulator therefore never sees a half-loaded set.
//
//   Frame: header word {nz[15:8], np[7:0]}, then nz+np signed values.
//   Value k goes to slot k, with zeros first and poles after them.
//
// Ports
//   clk       in   1                  system clock, rising edge
//   rst       in   1                  synchronous active-high reset
//   in_data   in   16                 stream word (header or value)
//   in_valid  in   1                  in_data valid
//   in_ready  out  1                  word can be accepted this cycle
//   flat_pz   out  16*REG_FILE_SIZE   active set, slot k at [16*k +: 16]
//   no_z      out  32                 active zero count
//   no_p      out  32                 active pole count
//   pz_valid  out  1                  high once any frame has committed
//   commit    out  1                  pulse: new active set visible
//   err       out  1                  pulse: oversize frame rejected
module pz_reg_loader #(
    parameter int REG_FILE_SIZE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [16*REG_FILE_SIZE-1:0] flat_pz,
    output logic [31:0]                 no_z,
    output logic [31:0]                 no_p,
    output logic                        pz_valid,
    output logic                        commit,
    output logic                        err
);

    localparam logic [8:0] SIZE9 = 9'(REG_FILE_SIZE);

    typedef enum logic [1:0] {HDR, LOAD, DISCARD, COMMIT} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [7:0]                  r_nz;
    logic [7:0]                  r_np;
    logic [7:0]                  r_act_nz;
    logic [7:0]                  r_act_np;
    logic [8:0]                  r_tot;
    logic [8:0]                  r_cnt;
    logic [15:0]                 r_shadow [REG_FILE_SIZE];
    logic [16*REG_FILE_SIZE-1:0] r_flat_pz;
    logic [16*REG_FILE_SIZE-1:0] w_masked;
    logic                        r_pz_valid;
    logic                        r_commit;
    logic                        r_err;
    logic                        w_accept;
    logic [8:0]                  w_hdr_tot;
    logic                        w_last;

    assign in_ready  = (r_state != COMMIT);
    assign w_accept  = in_valid && in_ready;
    // The sum is 9 bits wide so that nz+np never wraps.
    assign w_hdr_tot = {1'b0, in_data[15:8]} + {1'b0, in_data[7:0]};
    // This is only used in LOAD and DISCARD, where r_tot >= 1.
    assign w_last    = (r_cnt == r_tot - 9'd1);

    // Slots at or beyond the frame length may still hold values from an
    // older frame. They are zeroed on the way into the active set.
    genvar gi;
    generate
        for (gi = 0; gi < REG_FILE_SIZE; gi++) begin : g_mask
            assign w_masked[16*gi +: 16] = (9'(gi) < r_tot) ? r_shadow[gi] : 16'h0000;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HDR: begin
                if (w_accept) begin
                    if (w_hdr_tot == 9'd0)
                        w_state_next = COMMIT;
                    else if (w_hdr_tot > SIZE9)
                        w_state_next = DISCARD;
                    else
                        w_state_next = LOAD;
                end
            end
            LOAD:    if (w_accept && w_last) w_state_next = COMMIT;
            DISCARD: if (w_accept && w_last) w_state_next = HDR;
            COMMIT:  w_state_next = HDR;
            default: w_state_next = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HDR;
            r_nz       <= 8'd0;
            r_np       <= 8'd0;
            r_tot      <= 9'd0;
            r_cnt      <= 9'd0;
            r_act_nz   <= 8'd0;
            r_act_np   <= 8'd0;
            r_flat_pz  <= '0;
            r_pz_valid <= 1'b0;
            r_commit   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_commit <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                HDR: begin
                    if (w_accept) begin
                        r_nz  <= in_data[15:8];
                        r_np  <= in_data[7:0];
                        r_tot <= w_hdr_tot;
                        r_cnt <= 9'd0;
                        if (w_hdr_tot > SIZE9)
                            r_err <= 1'b1;
                    end
                end
                LOAD, DISCARD: begin
                    if (w_accept)
                        r_cnt <= r_cnt + 9'd1;
                end
                COMMIT: begin
                    r_flat_pz  <= w_masked;
                    r_act_nz   <= r_nz;
                    r_act_np   <= r_np;
                    r_commit   <= 1'b1;
                    r_pz_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shadow bank. Only LOAD writes it, so a discarded frame leaves it intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < REG_FILE_SIZE; k++)
                r_shadow[k] <= 16'h0000;
        end else if (r_state == LOAD && w_accept) begin
            for (int k = 0; k < REG_FILE_SIZE; k++)
                if (r_cnt == 9'(k))
                    r_shadow[k] <= in_data;
        end
    end

    assign flat_pz  = r_flat_pz;
    assign no_z     = {24'd0, r_act_nz};
    assign no_p     = {24'd0, r_act_np};
    assign pz_valid = r_pz_valid;
    assign commit   = r_commit;
    assign err      = r_err;

endmodule

// File: tb/tb_pz_reg_loader.sv
// Testbench for pz_reg_loader with REG_FILE_SIZE = 2.
// It applies a directed vector table, then hand-written multi-cycle corner
// cases, then random traffic checked against a frame-level reference model.
module tb_pz_reg_loader;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [16*N-1:0]   flat_pz;
    logic [31:0]       no_z;
    logic [31:0]       no_p;
    logic              pz_valid;
    logic              commit;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pz_reg_loader #(.REG_FILE_SIZE(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flat_pz  (flat_pz),
        .no_z     (no_z),
        .no_p     (no_p),
        .pz_valid (pz_valid),
        .commit   (commit),
        .err      (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic rdy, input logic cm,
                                 input logic er, input logic pzv,
                                 input logic [16*N-1:0] flat,
                                 input logic [7:0] nz, input logic [7:0] np);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        chk({tag, ".commit"},   64'(commit),   64'(cm));
        chk({tag, ".err"},      64'(err),      64'(er));
        chk({tag, ".pz_valid"}, 64'(pz_valid), 64'(pzv));
        chk({tag, ".flat_pz"},  64'(flat_pz),  64'(flat));
        chk({tag, ".no_z"},     64'(no_z),     64'({24'd0, nz}));
        chk({tag, ".no_p"},     64'(no_p),     64'({24'd0, np}));
    endtask

    // Drive inputs, then sample 1 time unit after the next rising edge.
    task automatic tick(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            v;
        logic [15:0]     d;
        logic            rdy;
        logic            cm;
        logic            er;
        logic            pzv;
        logic [16*N-1:0] flat;
        logic [7:0]      nz;
        logic [7:0]      np;
    } vec_t;

    vec_t tbl [18];

    // ---------------- reference model ----------------
    // Works at frame level. A queue collects the values of the current frame.
    // m_busy marks the single commit cycle, during which no word is taken.
    logic [15:0] m_act [N];
    logic [15:0] m_vals [$];
    logic [7:0]  m_nz, m_np, m_act_nz, m_act_np;
    int          m_tot, m_seen;
    logic        m_busy, m_in_frame, m_drop, m_pzv, m_exp_commit, m_exp_err;

    task automatic model_step(input logic r, input logic v, input logic [15:0] d);
        m_exp_commit = 1'b0;
        m_exp_err    = 1'b0;
        if (r) begin
            for (int k = 0; k < N; k++) m_act[k] = 16'h0;
            m_vals.delete();
            m_act_nz = 8'd0; m_act_np = 8'd0; m_nz = 8'd0; m_np = 8'd0;
            m_busy = 1'b0; m_in_frame = 1'b0; m_drop = 1'b0; m_pzv = 1'b0;
            m_tot = 0; m_seen = 0;
        end else if (m_busy) begin
            for (int k = 0; k < N; k++)
                m_act[k] = (k < m_vals.size()) ? m_vals[k] : 16'h0;
            m_act_nz = m_nz;
            m_act_np = m_np;
            m_pzv = 1'b1;
            m_exp_commit = 1'b1;
            m_busy = 1'b0;
        end else if (v) begin
            if (!m_in_frame) begin
                m_nz = d[15:8];
                m_np = d[7:0];
                m_tot = int'(m_nz) + int'(m_np);
                m_vals.delete();
                m_seen = 0;
                if (m_tot == 0) begin
                    m_busy = 1'b1;
                end else begin
                    m_in_frame = 1'b1;
                    m_drop = (m_tot > N);
                    m_exp_err = m_drop;
                end
            end else begin
                if (!m_drop) m_vals.push_back(d);
                m_seen++;
                if (m_seen == m_tot) begin
                    m_in_frame = 1'b0;
                    if (!m_drop) m_busy = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [16*N-1:0] model_flat();
        logic [16*N-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[16*k +: 16] = m_act[k];
        return f;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //            v     d         rdy   cm    er    pzv   flat          nz     np
        tbl[0]  = '{1'b1, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'd0, 8'd0};
        tbl[2]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'd0, 8'd0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0100, 8'd1, 8'd1};
        tbl[4]  = '{1'b1, 16'h0201, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 8'd1, 8'd1};
        tbl[5]  = '{1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 8'd1, 8'd1};
        tbl[6]  = '{1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 8'd1, 8'd1};
        tbl[7]  = '{1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 8'd1, 8'd1};
        tbl[8]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 8'd1, 8'd1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 8'd0, 8'd0};
        tbl[10] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 8'd0, 8'd0};
        tbl[11] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 8'd0, 8'd0};
        tbl[12] = '{1'b1, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 8'd0, 8'd0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5678_1234, 8'd0, 8'd2};
        tbl[14] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5678_1234, 8'd0, 8'd2};
        tbl[15] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5678_1234, 8'd0, 8'd2};
        // A word offered during the commit cycle must not be taken.
        tbl[16] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1};

        // Reset for two cycles.
        rst = 1'b1;
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);
        rst = 1'b0;
        $display("reset: ready=%0b flat=%h", in_ready, flat_pz);
        check_outputs("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0, 8'd0, 8'd0);

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].v, tbl[i].d);
            $display("vec %0d: valid=%0b data=%h ready=%0b commit=%0b err=%0b flat=%h",
                     i, tbl[i].v, tbl[i].d, in_ready, commit, err, flat_pz);
            check_outputs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].cm, tbl[i].er,
                          tbl[i].pzv, tbl[i].flat, tbl[i].nz, tbl[i].np);
        end

        // Frame with valid gaps 1-0-0-1-0-1.
        tick(1'b1, 16'h0101); check_outputs("gap0", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1);
        tick(1'b0, 16'h0000); check_outputs("gap1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1);
        tick(1'b0, 16'h0000); check_outputs("gap2", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1);
        tick(1'b1, 16'h0100); check_outputs("gap3", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1);
        tick(1'b0, 16'h0000); check_outputs("gap4", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1);
        tick(1'b1, 16'h0040); check_outputs("gap5", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 8'd0, 8'd1);
        tick(1'b0, 16'h0000); check_outputs("gap6", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0100, 8'd1, 8'd1);
        tick(1'b0, 16'h0000); check_outputs("gap7", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 8'd1, 8'd1);
        $display("gap frame: flat=%h no_z=%0d no_p=%0d", flat_pz, no_z, no_p);

        // Reset in the middle of a frame, then a clean frame.
        tick(1'b1, 16'h0002);
        tick(1'b1, 16'h1111);
        rst = 1'b1;
        tick(1'b1, 16'h2222);
        rst = 1'b0;
        check_outputs("midrst", 1'b1, 1'b0, 1'b0, 1'b0, '0, 8'd0, 8'd0);
        tick(1'b1, 16'h0002);
        tick(1'b1, 16'h8000);
        tick(1'b1, 16'h0001); check_outputs("post_rst_last", 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'd0, 8'd0);
        tick(1'b0, 16'h0000); check_outputs("post_rst_commit", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0001_8000, 8'd0, 8'd2);
        $display("post-reset frame: flat=%h", flat_pz);

        // Random traffic against the reference model.
        rst = 1'b1;
        model_step(1'b1, 1'b0, 16'h0000);
        tick(1'b0, 16'h0000);
        rst = 1'b0;
        check_outputs("rnd_reset", 1'b1, 1'b0, 1'b0, 1'b0, '0, 8'd0, 8'd0);
        for (int c = 0; c < 1500; c++) begin
            logic        r, v;
            logic [15:0] d;
            logic [7:0]  hnz, hnp;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            if (!m_in_frame && !m_busy) begin
                hnz = 8'($urandom_range(0, 2));
                hnp = 8'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) hnz = 8'($urandom_range(0, 12));
                d = {hnz, hnp};
            end else begin
                d = 16'($urandom);
            end
            rst = r;
            model_step(r, v, d);
            tick(v, d);
            check_outputs($sformatf("rnd%0d", c), !m_busy, m_exp_commit, m_exp_err,
                          m_pzv, model_flat(), m_act_nz, m_act_np);
            if (r)
                $display("rnd %0d: reset", c);
            else if (m_exp_commit || m_exp_err)
                $display("rnd %0d: commit=%0b err=%0b flat=%h no_z=%0d no_p=%0d",
                         c, commit, err, flat_pz, no_z, no_p);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
